// File: rtl/seg_pkg.sv
// Shared types and segment codes for the seven-segment scan controller.
package seg_pkg;

  // Active-low segment codes, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder; codes 10..15 render blank.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Pure table lookup
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment bank.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | scan disabled, display dark, idx held at 0
// SHOW  | digit idx lit for PRESCALE cycles
// BLANK | all anodes off for BLANK_CYCLES cycles (idx already advanced)
//
// Outputs are registered from next-state/next-idx so the pins move on the
// same edge as the state. Segment data comes from the current register
// file, so a write to the lit digit shows one cycle after its write edge.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          lz_blank,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  input  logic                          wr_dp,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [6:0]                    seg,
  output logic                          dp_n,
  output logic                          frame_tick
);

  localparam int AW      = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] PRE_LOAD = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLK_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_DIGITS - 1);

  scan_state_t r_state;
  scan_state_t w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_wrap;

  logic [NUM_DIGITS-1:0][3:0] r_digit;
  logic [NUM_DIGITS-1:0]      r_dp;

  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic                  w_zero_above;
  logic [NUM_DIGITS-1:0] w_an_onehot;
  logic [3:0]            w_dec_in;
  logic [6:0]            w_seg_dec;

  logic [NUM_DIGITS-1:0] r_an_n;
  logic [6:0]            r_seg;
  logic                  r_dp_n;
  logic                  r_frame_tick;

  // Digit register file; out-of-range addresses are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
      r_dp    <= '0;
    end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      r_digit[wr_addr] <= wr_data;
      r_dp[wr_addr]    <= wr_dp;
    end
  end

  // State, index and slot down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: slot timing, index advance and wrap detection
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_wrap      = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = SHOW;
          w_idx_nxt   = '0;
          w_cnt_nxt   = PRE_LOAD;
        end
        SHOW: begin
          if (r_cnt == '0) begin
            w_wrap    = (r_idx == LAST_IDX);
            w_idx_nxt = w_wrap ? '0 : r_idx + AW'(1);
            if (BLANK_CYCLES == 0) begin
              w_state_nxt = SHOW;
              w_cnt_nxt   = PRE_LOAD;
            end else begin
              w_state_nxt = BLANK;
              w_cnt_nxt   = BLK_LOAD;
            end
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
        BLANK: begin
          if (r_cnt == '0) begin
            w_state_nxt = SHOW;
            w_cnt_nxt   = PRE_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Leading-zero mask: bit i set when digit i and every digit above it are 0
  always_comb begin
    w_lz_mask    = '0;
    w_zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above & (r_digit[i] == 4'd0);
      w_lz_mask[i] = w_zero_above;
    end
  end

  // Select the digit that will be lit after this edge
  always_comb begin
    w_an_onehot            = '0;
    w_an_onehot[w_idx_nxt] = 1'b1;
    w_dec_in               = (lz_blank && w_lz_mask[w_idx_nxt]) ? 4'hF : r_digit[w_idx_nxt];
  end

  seg7_decode u_decode (
    .i_bcd (w_dec_in),
    .o_seg (w_seg_dec)
  );

  // Registered pin drivers, dark unless the next state is SHOW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_n       <= '1;
      r_seg        <= SEG_BLANK;
      r_dp_n       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap;
      if (w_state_nxt == SHOW) begin
        r_an_n <= ~w_an_onehot;
        r_seg  <= w_seg_dec;
        r_dp_n <= ~r_dp[w_idx_nxt];
      end else begin
        r_an_n <= '1;
        r_seg  <= SEG_BLANK;
        r_dp_n <= 1'b1;
      end
    end
  end

  assign an_n       = r_an_n;
  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a per-cycle expected-output queue.
module tb_seg_scan_ctrl;

  localparam int PRE = 4;
  localparam int BLK = 2;
  localparam int SLOT = PRE + BLK;

  logic       clk;
  logic       rst_n;
  logic       en, lz_blank, wr_en, wr_dp;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] an_n;
  logic [6:0] seg;
  logic       dp_n, frame_tick;

  logic       en3, wr_en3, wr_dp3;
  logic [1:0] wr_addr3;
  logic [3:0] wr_data3;
  logic [2:0] an_n3;
  logic [6:0] seg3;
  logic       dp_n3, frame_tick3;

  int n_checks = 0;
  int n_err    = 0;

  logic [3:0]  m_dig [8];
  logic        m_dp  [8];
  logic        m_lz;
  logic [16:0] sb_q [$];

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(PRE), .BLANK_CYCLES(BLK)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lz_blank(lz_blank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
    .an_n(an_n), .seg(seg), .dp_n(dp_n), .frame_tick(frame_tick)
  );

  seg_scan_ctrl #(.NUM_DIGITS(3), .PRESCALE(PRE), .BLANK_CYCLES(BLK)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .lz_blank(1'b0),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_dp(wr_dp3),
    .an_n(an_n3), .seg(seg3), .dp_n(dp_n3), .frame_tick(frame_tick3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dec_m(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {an(8), seg, dp_n, frame_tick} at sample k after the enable edge
  function automatic logic [16:0] exp_out(input int k, input int nd);
    int period, slot, d;
    logic [7:0] an;
    logic [6:0] sg;
    logic dpn, ft, blank;
    period = nd * SLOT;
    slot   = k % SLOT;
    d      = (k / SLOT) % nd;
    ft     = ((k % period) == period - 2);
    an     = 8'hFF;
    sg     = 7'h7F;
    dpn    = 1'b1;
    if (slot < PRE) begin
      an[d] = 1'b0;
      blank = m_lz && (d > 0);
      for (int j = d; j < nd; j++) if (m_dig[j] != 4'd0) blank = 1'b0;
      sg  = blank ? 7'h7F : dec_m(m_dig[d]);
      dpn = ~m_dp[d];
    end
    return {an, sg, dpn, ft};
  endfunction

  function automatic logic [16:0] obs(input int nd);
    if (nd == 3) return {5'h1F, an_n3, seg3, dp_n3, frame_tick3};
    return {4'hF, an_n, seg, dp_n, frame_tick};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed an/seg/dp/ft=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push n expectations, then pop one per clock as the DUT produces it
  task automatic run_expect(input string tag, input int k0, input int n, input int nd);
    logic [16:0] want;
    for (int i = 0; i < n; i++) sb_q.push_back(exp_out(k0 + i, nd));
    for (int i = 0; i < n; i++) begin
      step();
      want = sb_q.pop_front();
      check($sformatf("%s[k=%0d]", tag, k0 + i), obs(nd), want);
    end
  endtask

  task automatic check_dark(input string tag, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(17'h1FFFE);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, obs(4), sb_q.pop_front());
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wr3(input logic [1:0] a, input logic [3:0] d, input logic p);
    wr_en3 = 1'b1; wr_addr3 = a; wr_data3 = d; wr_dp3 = p;
    step();
    wr_en3 = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_dig[i] = 4'd0;
      m_dp[i]  = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; lz_blank = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0;
    en3 = 1'b0; wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0; wr_dp3 = 1'b0;
    model_clear();
    m_lz = 1'b0;

    // Reset values
    #12;
    check("reset_dark", obs(4), 17'h1FFFE);
    #3 rst_n = 1'b1;
    step();
    check_dark("idle_dark", 2);

    // Full scan: d3..d0 = 4,3,2,1
    wr(2'd0, 4'd1, 1'b0); wr(2'd1, 4'd2, 1'b0);
    wr(2'd2, 4'd3, 1'b0); wr(2'd3, 4'd4, 1'b0);
    m_dig[0] = 4'd1; m_dig[1] = 4'd2; m_dig[2] = 4'd3; m_dig[3] = 4'd4;
    check_dark("idle_after_wr", 1);
    en = 1'b1;
    run_expect("full_scan", 0, 48, 4);

    // Reset in the middle of digit 2's SHOW slot
    run_expect("to_digit2", 48, 14, 4);
    #2 rst_n = 1'b0;
    #1 check("async_reset", obs(4), 17'h1FFFE);
    model_clear();
    #3 rst_n = 1'b1;
    run_expect("post_reset", 0, 12, 4);

    // Codes 10..15 render blank without disturbing timing
    en = 1'b0;
    check_dark("en_off", 1);
    wr(2'd0, 4'd1, 1'b0); wr(2'd1, 4'd12, 1'b0);
    wr(2'd2, 4'd3, 1'b0); wr(2'd3, 4'd4, 1'b0);
    m_dig[0] = 4'd1; m_dig[1] = 4'd12; m_dig[2] = 4'd3; m_dig[3] = 4'd4;
    en = 1'b1;
    run_expect("code12", 0, 24, 4);

    // Leading-zero blanking with dp on a blanked digit: d3..d0 = 0,0,7,0
    en = 1'b0;
    check_dark("en_off2", 1);
    wr(2'd0, 4'd0, 1'b0); wr(2'd1, 4'd7, 1'b0);
    wr(2'd2, 4'd0, 1'b1); wr(2'd3, 4'd0, 1'b0);
    m_dig[0] = 4'd0; m_dig[1] = 4'd7; m_dig[2] = 4'd0; m_dig[3] = 4'd0;
    m_dp[2] = 1'b1;
    lz_blank = 1'b1; m_lz = 1'b1;
    en = 1'b1;
    run_expect("lz_on", 0, 24, 4);
    en = 1'b0;
    check_dark("en_off3", 1);
    lz_blank = 1'b0; m_lz = 1'b0;
    en = 1'b1;
    run_expect("lz_off", 0, 24, 4);

    // Enable dropped in the 3rd cycle of digit 1's slot, then restarted
    en = 1'b0;
    check_dark("en_off4", 1);
    en = 1'b1;
    run_expect("pre_toggle", 0, 9, 4);
    en = 1'b0;
    check_dark("toggle_dark", 3);
    en = 1'b1;
    run_expect("re_enable", 0, 12, 4);

    // Live write to the lit digit 0
    en = 1'b0;
    check_dark("en_off5", 1);
    en = 1'b1;
    run_expect("live_pre", 0, 2, 4);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd8; wr_dp = 1'b1;
    run_expect("live_wr_edge", 2, 1, 4);
    wr_en = 1'b0;
    m_dig[0] = 4'd8; m_dp[0] = 1'b1;
    run_expect("live_post", 3, 27, 4);
    en = 1'b0;

    // Three-digit build: out-of-range address must not disturb the file
    wr3(2'd0, 4'd5, 1'b0); wr3(2'd1, 4'd6, 1'b0); wr3(2'd2, 4'd9, 1'b0);
    wr3(2'd3, 4'd1, 1'b1);
    model_clear();
    m_lz = 1'b0;
    m_dig[0] = 4'd5; m_dig[1] = 4'd6; m_dig[2] = 4'd9;
    en3 = 1'b1;
    run_expect("nd3_oob", 0, 36, 3);
    en3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
